// File: rtl/axi4lite_cpu_if_bridge.sv
// axi4lite_cpu_if_bridge: AXI4-Lite slave to cpu_if master bridge with an access watchdog
// Ports: l_clk/l_reset_n (async active-low); s_axi_aw*/w*/b* write channels;
// s_axi_ar*/r* read channels; l_cpu_if_read/write/address/write_data requests out;
// l_cpu_if_read_data/access_complete completions in.
module axi4lite_cpu_if_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        l_clk,
  input  logic        l_reset_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        l_cpu_if_read,
  output logic        l_cpu_if_write,
  output logic [29:0] l_cpu_if_address,
  output logic [31:0] l_cpu_if_write_data,
  input  logic [31:0] l_cpu_if_read_data,
  input  logic        l_cpu_if_access_complete
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, WR_ACC, RD_ACC, WR_RESP, RD_RESP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic last_wr, wr_go, rd_go, expire, done, unused;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  always_ff @(posedge l_clk or negedge l_reset_n)
    if (!l_reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    // on a tie the type not granted last time wins
    wr_go = (state == IDLE) && s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !last_wr);
    rd_go = (state == IDLE) && s_axi_arvalid && !wr_go;
    // request has been up TIMEOUT_CYCLES cycles once this is its last cycle
    expire = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    done = l_cpu_if_access_complete || expire;
    s_axi_awready = wr_go;
    s_axi_wready = wr_go;
    s_axi_arready = rd_go;
    s_axi_bvalid = state == WR_RESP;
    s_axi_rvalid = state == RD_RESP;
    l_cpu_if_write = state == WR_ACC;
    l_cpu_if_read = state == RD_ACC;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = wr_go ? ((s_axi_wstrb == 4'hF) ? WR_ACC : WR_RESP) : rd_go ? RD_ACC : IDLE;
      WR_ACC:  state_nxt = done ? WR_RESP : WR_ACC;
      RD_ACC:  state_nxt = done ? RD_RESP : RD_ACC;
      WR_RESP: state_nxt = s_axi_bready ? IDLE : WR_RESP;
      RD_RESP: state_nxt = s_axi_rready ? IDLE : RD_RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge l_clk or negedge l_reset_n)
    if (!l_reset_n) begin
      cnt <= '0;
      last_wr <= 1'b0;
      l_cpu_if_address <= '0;
      l_cpu_if_write_data <= '0;
      s_axi_bresp <= 2'b00;
      s_axi_rresp <= 2'b00;
      s_axi_rdata <= '0;
    end else begin
      if (wr_go || rd_go) begin
        l_cpu_if_address <= wr_go ? s_axi_awaddr[31:2] : s_axi_araddr[31:2];
        cnt <= '0;
        last_wr <= wr_go;
      end else if (l_cpu_if_write || l_cpu_if_read) cnt <= cnt + 1'b1;
      if (wr_go) begin
        l_cpu_if_write_data <= s_axi_wdata;
        s_axi_bresp <= (s_axi_wstrb == 4'hF) ? 2'b00 : 2'b10;
      end
      // completion beats a same-cycle expiry
      if (l_cpu_if_write && done) s_axi_bresp <= l_cpu_if_access_complete ? 2'b00 : 2'b10;
      if (l_cpu_if_read && done) begin
        s_axi_rresp <= l_cpu_if_access_complete ? 2'b00 : 2'b10;
        s_axi_rdata <= l_cpu_if_access_complete ? l_cpu_if_read_data : ERR_RDATA;
      end
    end
endmodule

// File: tb/tb_axi4lite_cpu_if_bridge.sv
// tb_axi4lite_cpu_if_bridge: randomized bench for the AXI4-Lite to cpu_if bridge
module tb_axi4lite_cpu_if_bridge;
  localparam int T = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic l_reset_n;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata, l_cpu_if_write_data, l_cpu_if_read_data;
  logic [3:0] s_axi_wstrb;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [29:0] l_cpu_if_address;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic l_cpu_if_read, l_cpu_if_write, l_cpu_if_access_complete;
  always #5 clk = ~clk;
  axi4lite_cpu_if_bridge #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
    .l_clk(clk), .l_reset_n(l_reset_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .l_cpu_if_read(l_cpu_if_read), .l_cpu_if_write(l_cpu_if_write), .l_cpu_if_address(l_cpu_if_address),
    .l_cpu_if_write_data(l_cpu_if_write_data), .l_cpu_if_read_data(l_cpu_if_read_data),
    .l_cpu_if_access_complete(l_cpu_if_access_complete)
  );
  int vectors = 0, miscompares = 0;
  bit chk_en = 0;
  bit m_awready, m_arready, m_req_wr, m_req_rd, m_bvalid, m_rvalid, last_wr_m;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [1:0] m_resp;
  int req_seen = 0, rv_seen = 0;
  logic [31:0] lit_addr, lit_wdata, lit_rdata;
  logic [1:0] lit_bresp, lit_rresp;
  logic [7:0] glog = 8'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("awready", 32'(s_axi_awready), 32'(m_awready));
    chk("wready", 32'(s_axi_wready), 32'(m_awready));
    chk("arready", 32'(s_axi_arready), 32'(m_arready));
    chk("cpu_write", 32'(l_cpu_if_write), 32'(m_req_wr));
    chk("cpu_read", 32'(l_cpu_if_read), 32'(m_req_rd));
    chk("rd_wr_exclusive", 32'(l_cpu_if_read & l_cpu_if_write), 32'd0);
    chk("bvalid", 32'(s_axi_bvalid), 32'(m_bvalid));
    chk("rvalid", 32'(s_axi_rvalid), 32'(m_rvalid));
    if (m_req_wr || m_req_rd) chk("address", 32'(l_cpu_if_address), 32'(m_addr));
    if (m_req_wr) chk("write_data", l_cpu_if_write_data, m_wdata);
    if (m_bvalid) chk("bresp", 32'(s_axi_bresp), 32'(m_resp));
    if (m_rvalid) begin
      chk("rresp", 32'(s_axi_rresp), 32'(m_resp));
      chk("rdata", s_axi_rdata, m_rdata);
    end
    if (l_cpu_if_read || l_cpu_if_write) begin
      req_seen++;
      lit_addr = 32'(l_cpu_if_address);
      lit_wdata = l_cpu_if_write_data;
    end
    if (s_axi_bvalid) lit_bresp = s_axi_bresp;
    if (s_axi_rvalid) begin
      rv_seen++;
      lit_rresp = s_axi_rresp;
      lit_rdata = s_axi_rdata;
    end
    if (s_axi_awready) glog = {glog[6:0], 1'b1};
    else if (s_axi_arready) glog = {glog[6:0], 1'b0};
  end
  task automatic clr_model;
    {m_awready, m_arready, m_req_wr, m_req_rd, m_bvalid, m_rvalid} = '0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready} = '0;
      clr_model();
      l_cpu_if_access_complete = 1'($urandom_range(0, 1));
      l_cpu_if_read_data = $urandom;
      @(posedge clk); #1;
    end
    l_cpu_if_access_complete = 1'b0;
  endtask
  // One transaction: d = request cycle carrying complete (d > T means never), stall = rready/bready delay
  task automatic txn(input bit tie, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, input int d, input logic [31:0] rdv, input int stall);
    bit w, acc, ok;
    int n;
    logic [31:0] ra, a;
    ra = tie ? (addr ^ 32'h0000_0100) : addr;
    w = tie ? !last_wr_m : wr;
    a = w ? addr : ra;
    acc = !w || (strb == 4'hF);
    ok = acc && (d <= T);
    n = (d <= T) ? d : T;
    s_axi_awaddr = addr; s_axi_wdata = wd; s_axi_wstrb = strb; s_axi_araddr = ra;
    s_axi_awvalid = tie | wr; s_axi_wvalid = tie | wr; s_axi_arvalid = tie | !wr;
    s_axi_bready = 0; s_axi_rready = 0; l_cpu_if_access_complete = 0; l_cpu_if_read_data = $urandom;
    clr_model();
    m_awready = w; m_arready = !w; last_wr_m = w;
    @(posedge clk); #1;
    if (!tie) {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid} = '0;
    m_awready = 0; m_arready = 0; m_addr = a[31:2]; m_wdata = wd;
    if (acc) for (int i = 1; i <= n; i++) begin
      m_req_wr = w; m_req_rd = !w;
      l_cpu_if_access_complete = (i == d);
      l_cpu_if_read_data = (i == d) ? rdv : $urandom;
      @(posedge clk); #1;
    end
    m_req_wr = 0; m_req_rd = 0; l_cpu_if_access_complete = 0;
    m_bvalid = w; m_rvalid = !w; m_resp = ok ? 2'b00 : 2'b10; m_rdata = ok ? rdv : ERR;
    for (int j = 0; j <= stall; j++) begin
      s_axi_bready = w && (j == stall);
      s_axi_rready = !w && (j == stall);
      @(posedge clk); #1;
    end
    s_axi_bready = 0; s_axi_rready = 0; m_bvalid = 0; m_rvalid = 0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    l_reset_n = 1'b0;
    {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready, l_cpu_if_access_complete} = '0;
    s_axi_awaddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_araddr = 0; l_cpu_if_read_data = 0;
    last_wr_m = 0;
    clr_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(s_axi_awready), 0);
    chk("rst_arready", 32'(s_axi_arready), 0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 0);
    chk("rst_bresp", 32'(s_axi_bresp), 0);
    chk("rst_rresp", 32'(s_axi_rresp), 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_req", 32'({l_cpu_if_read, l_cpu_if_write}), 0);
    chk("rst_address", 32'(l_cpu_if_address), 0);
    chk("rst_write_data", l_cpu_if_write_data, 0);
    l_reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    req_seen = 0;
    txn(0, 1, 32'h0000_0104, 32'hA5A5_0001, 4'hF, 3, 0, 0);
    chk("wr_req_cycles", req_seen, 3);
    chk("wr_address", lit_addr, 32'h41);
    chk("wr_data", lit_wdata, 32'hA5A5_0001);
    chk("wr_bresp", 32'(lit_bresp), 0);
    idle(1);
    req_seen = 0; rv_seen = 0;
    txn(0, 0, 32'h10, 0, 4'hF, 1, 32'h1234_5678, 5);
    chk("rd_req_cycles", req_seen, 1);
    chk("rd_rvalid_cycles", rv_seen, 6);
    chk("rd_rdata", lit_rdata, 32'h1234_5678);
    chk("rd_rresp", 32'(lit_rresp), 0);
    idle(2);
    req_seen = 0;
    txn(0, 1, 32'h20, 32'h77, 4'h3, 1, 0, 1);
    chk("partial_req_cycles", req_seen, 0);
    chk("partial_bresp", 32'(lit_bresp), 2);
    idle(1);
    req_seen = 0;
    txn(0, 0, 32'h44, 0, 4'hF, T + 1, 0, 0);
    chk("timeout_req_cycles", req_seen, T);
    chk("timeout_rresp", 32'(lit_rresp), 2);
    chk("timeout_rdata", lit_rdata, 32'hDEAD_BEEF);
    idle(1);
    req_seen = 0;
    txn(0, 0, 32'h48, 0, 4'hF, T, 32'h0BAD_0008, 1);
    chk("late_req_cycles", req_seen, T);
    chk("late_rresp", 32'(lit_rresp), 0);
    chk("late_rdata", lit_rdata, 32'h0BAD_0008);
    idle(1);
    chk_en = 0;
    s_axi_awaddr = 32'h200; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge clk); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(posedge clk); #1;
    chk("pre_reset_write", 32'(l_cpu_if_write), 1);
    #2 l_reset_n = 1'b0;
    #1;
    chk("arst_write", 32'(l_cpu_if_write), 0);
    chk("arst_address", 32'(l_cpu_if_address), 0);
    chk("arst_write_data", l_cpu_if_write_data, 0);
    chk("arst_bvalid", 32'(s_axi_bvalid), 0);
    @(posedge clk); #1;
    l_reset_n = 1'b1;
    last_wr_m = 0;
    chk_en = 1;
    idle(4);
    txn(0, 0, 32'h30, 0, 4'hF, 2, 32'hCAFE_0001, 0);
    chk("post_reset_rdata", lit_rdata, 32'hCAFE_0001);
    idle(1);
    glog = 0;
    for (int k = 0; k < 4; k++) txn(1, 0, 32'h400 + 32'(k * 4), $urandom, 4'hF, $urandom_range(1, 3), $urandom, $urandom_range(0, 2));
    chk("tie_order", 32'(glog[3:0]), 32'b1010);
    idle(1);
    for (int k = 0; k < 60; k++) begin
      bit tie;
      logic [3:0] st;
      tie = $urandom_range(0, 3) == 0;
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      txn(tie, 1'($urandom), $urandom, $urandom, st, $urandom_range(1, T + 2), $urandom, $urandom_range(0, 3));
      if (!tie) idle($urandom_range(0, 2));
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
